// File: rtl/angle_unwrapper_if.sv
// Sample/result bundle for angle_unwrapper: reduced angle in, unwrapped angle and status out.
// master drives the samples, slave is the unwrapper.
interface angle_unwrapper_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TURN_WIDTH = 16
);
   logic                  en_unwrap;
   logic                  clear;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic [TURN_WIDTH-1:0] turns;
   logic                  range_err;
   logic                  overflow;

   modport master (
      output en_unwrap, clear, data_in,
      input  data_out, valid_out, turns, range_err, overflow
   );

   modport slave (
      input  en_unwrap, clear, data_in,
      output data_out, valid_out, turns, range_err, overflow
   );
endinterface

// File: rtl/angle_unwrapper.sv
// Unwraps a modulo-360 angle stream into turns*360 + angle; two-stage pipeline, one sample
// per cycle, no backpressure. The interface instance must use the same widths as this module.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module angle_unwrapper #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int TURN_WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   angle_unwrapper_if.slave u
);
   typedef enum logic {FIRST, TRACK} state_t;

   localparam logic [DATA_WIDTH-1:0] DEG_360  = DATA_WIDTH'(360);
   localparam logic [TURN_WIDTH-1:0] TURN_MAX = {1'b0, {(TURN_WIDTH-1){1'b1}}};
   localparam logic [TURN_WIDTH-1:0] TURN_MIN = {1'b1, {(TURN_WIDTH-1){1'b0}}};
   localparam logic [TURN_WIDTH-1:0] TURN_ONE = TURN_WIDTH'(1);

   state_t                state;
   logic [8:0]            prev;
   logic [8:0]            angle_s1;
   logic [TURN_WIDTH-1:0] turns_s1;
   logic                  valid_s1;
   logic [DATA_WIDTH-1:0] data_out_r;
   logic                  valid_out_r;
   logic                  range_err_r;
   logic                  overflow_r;

   logic                  in_range;
   logic signed [9:0]     delta;
   logic                  wrap_fwd;
   logic                  wrap_bwd;
   logic [DATA_WIDTH-1:0] turns_ext;
   logic [DATA_WIDTH-1:0] unwrapped;

   assign in_range  = u.data_in < DEG_360;
   assign delta     = $signed({1'b0, u.data_in[8:0]}) - $signed({1'b0, prev});
   assign wrap_fwd  = delta < -10'sd180;
   assign wrap_bwd  = delta > 10'sd180;
   // Modular product: low DATA_WIDTH bits are the same for signed or unsigned once sign-extended.
   assign turns_ext = {{(DATA_WIDTH-TURN_WIDTH){turns_s1[TURN_WIDTH-1]}}, turns_s1};
   assign unwrapped = turns_ext * DEG_360 + {{(DATA_WIDTH-9){1'b0}}, angle_s1};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= FIRST;
         prev        <= '0;
         angle_s1    <= '0;
         turns_s1    <= '0;
         valid_s1    <= 1'b0;
         data_out_r  <= '0;
         valid_out_r <= 1'b0;
         range_err_r <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         valid_out_r <= valid_s1;
         if (valid_s1)
            data_out_r <= unwrapped;
         valid_s1    <= 1'b0;
         range_err_r <= u.en_unwrap && !in_range;

         if (u.clear) begin
            turns_s1   <= '0;
            overflow_r <= 1'b0;
            state      <= FIRST;
         end

         // A sample arriving with clear is taken as the first one after restart.
         if (u.en_unwrap && in_range) begin
            prev     <= u.data_in[8:0];
            angle_s1 <= u.data_in[8:0];
            valid_s1 <= 1'b1;
            state    <= TRACK;
            if (!u.clear && state == TRACK) begin
               if (wrap_fwd) begin
                  if (turns_s1 == TURN_MAX) overflow_r <= 1'b1;
                  else                      turns_s1   <= turns_s1 + TURN_ONE;
               end else if (wrap_bwd) begin
                  if (turns_s1 == TURN_MIN) overflow_r <= 1'b1;
                  else                      turns_s1   <= turns_s1 - TURN_ONE;
               end
            end
         end
      end
   end

   assign u.data_out  = data_out_r;
   assign u.valid_out = valid_out_r;
   assign u.turns     = turns_s1;
   assign u.range_err = range_err_r;
   assign u.overflow  = overflow_r;
endmodule

// File: tb/tb_angle_unwrapper.sv
// Directed bench for angle_unwrapper: integer reference model checked every cycle plus
// hand-computed literal expectations at key points.
module tb_angle_unwrapper;
   localparam int DW = 16;
   localparam int TW = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   angle_unwrapper_if #(.DATA_WIDTH(DW), .TURN_WIDTH(TW)) u ();

   angle_unwrapper #(.DATA_WIDTH(DW), .TURN_WIDTH(TW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .u       (u)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Reference model state: what the outputs must show after the latest edge.
   bit m_first = 1'b1;
   int m_prev  = 0;
   int e_turns = 0;
   bit e_ovf   = 1'b0;
   bit e_rerr  = 1'b0;
   bit e_valid = 1'b0;
   int e_data  = 0;
   bit p_valid = 1'b0;
   int p_data  = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model(input bit en, input bit clr, input int din, input bit rst);
      int d;
      if (rst) begin
         m_first = 1'b1; m_prev = 0; e_turns = 0; e_ovf = 1'b0; e_rerr = 1'b0;
         e_valid = 1'b0; e_data = 0; p_valid = 1'b0; p_data = 0;
         return;
      end
      e_valid = p_valid;
      if (p_valid) e_data = p_data;
      p_valid = 1'b0;
      e_rerr  = 1'b0;
      if (clr) begin
         e_turns = 0; e_ovf = 1'b0; m_first = 1'b1;
      end
      if (en) begin
         if (din >= 360) begin
            e_rerr = 1'b1;
         end else begin
            if (!m_first) begin
               d = din - m_prev;
               if (d < -180) begin
                  if (e_turns == 7) e_ovf = 1'b1; else e_turns++;
               end else if (d > 180) begin
                  if (e_turns == -8) e_ovf = 1'b1; else e_turns--;
               end
            end
            m_first = 1'b0;
            m_prev  = din;
            p_valid = 1'b1;
            p_data  = (e_turns * 360 + din) & 32'h0000_FFFF;
         end
      end
   endtask

   task automatic step(input bit en, input bit clr, input int din);
      u.en_unwrap = en;
      u.clear     = clr;
      u.data_in   = 16'(din);
      @(posedge clk);
      #1;
      model(en, clr, din, !reset_n);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid_out", u.valid_out, e_valid);
         chk("data_out", u.data_out, e_data);
         chk("turns", $signed(u.turns), e_turns);
         chk("range_err", u.range_err, e_rerr);
         chk("overflow", u.overflow, e_ovf);
      end
   end

   initial begin
      u.en_unwrap = 1'b0;
      u.clear     = 1'b0;
      u.data_in   = '0;

      reset_n = 1'b0;
      step(0, 0, 0);
      step(0, 0, 0);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      @(negedge clk);
      chk("rst_data_out", u.data_out, 0);
      chk("rst_turns", $signed(u.turns), 0);
      chk("rst_overflow", u.overflow, 0);

      // First sample after reset
      step(1, 0, 10);
      step(0, 0, 0);
      @(negedge clk);
      chk("first_valid", u.valid_out, 1);
      chk("first_data", u.data_out, 10);

      // Forward wrap, with an idle gap in the middle
      step(0, 1, 0);
      step(1, 0, 350);
      step(0, 0, 0);
      step(1, 0, 5);
      @(negedge clk);
      chk("fwd_turns_early", $signed(u.turns), 1);
      step(1, 0, 20);
      step(0, 0, 0);
      @(negedge clk);
      chk("fwd_data_380", u.data_out, 380);

      // Backward wrap and delta of exactly -180
      step(0, 1, 0);
      step(1, 0, 10);
      step(1, 0, 350);
      step(0, 0, 0);
      @(negedge clk);
      chk("bwd_data_m10", u.data_out, 16'hFFF6);
      chk("bwd_turns", $signed(u.turns), -1);
      step(1, 0, 170);
      step(0, 0, 0);
      @(negedge clk);
      chk("bwd_data_m190", u.data_out, 16'hFF42);

      // Delta of exactly +180 then -180: no turn change
      step(0, 1, 0);
      step(1, 0, 0);
      step(1, 0, 180);
      step(1, 0, 0);
      step(0, 0, 0);
      @(negedge clk);
      chk("pm180_turns", $signed(u.turns), 0);

      // Range error
      step(0, 1, 0);
      step(1, 0, 100);
      step(1, 0, 400);
      @(negedge clk);
      chk("rerr_pulse", u.range_err, 1);
      step(1, 0, 90);
      @(negedge clk);
      chk("rerr_gone", u.range_err, 0);
      step(0, 0, 0);
      @(negedge clk);
      chk("rerr_data_90", u.data_out, 90);

      // Saturation: ten forward wraps into a 4-bit counter
      step(0, 1, 0);
      for (int i = 0; i < 11; i++) begin
         step(1, 0, 0);
         step(1, 0, 120);
         step(1, 0, 240);
      end
      step(0, 0, 0);
      @(negedge clk);
      chk("sat_turns", $signed(u.turns), 7);
      chk("sat_overflow", u.overflow, 1);
      chk("sat_data", u.data_out, 2760);
      step(0, 1, 0);
      @(negedge clk);
      chk("sat_clr_turns", $signed(u.turns), 0);
      chk("sat_clr_ovf", u.overflow, 0);

      // clear together with a sample; in-flight sample keeps its turns
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0);
         step(1, 0, 120);
         step(1, 0, 240);
      end
      @(negedge clk);
      chk("ce_turns3", $signed(u.turns), 3);
      step(1, 1, 50);
      @(negedge clk);
      chk("ce_turns0", $signed(u.turns), 0);
      chk("ce_inflight", u.data_out, 1320);
      step(0, 0, 0);
      @(negedge clk);
      chk("ce_data50", u.data_out, 50);

      // Reset one cycle after a sample drops it
      step(1, 0, 100);
      reset_n = 1'b0;
      step(0, 0, 0);
      @(negedge clk);
      chk("midrst_valid", u.valid_out, 0);
      reset_n = 1'b1;
      step(0, 0, 0);
      @(negedge clk);
      chk("midrst_valid2", u.valid_out, 0);
      step(0, 0, 0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
